population_initializer: RTL and testbench
=========================================

// Module: population_initializer
// PURPOSE
//  Upstream feeder of population_memory. On a start pulse, fills every slot 0..POPULATION_SIZE-1
//  with a pseudo-random chromosome from an internal 16-bit LFSR, one write per cycle.
//  Its write_enable/write_addr/write_data outputs drive the memory's write port directly.
//  Signals completion with a one-cycle done pulse, then returns to idle.
// PARAMETERS
//  CHROMOSOME_WIDTH  8                         chromosome bits; legal range 1..16
//  POPULATION_SIZE   16                        number of slots to fill; >=2
//  ADDR_WIDTH        $clog2(POPULATION_SIZE)   write address width
// PORTS
//  clk            in   1                 single clock; all logic on posedge
//  rst_n          in   1                 reset, synchronous, active-low
//  start          in   1                 begin fill; sampled only in IDLE
//  seed           in   16                LFSR seed, captured on accepted start
//  hold           in   1                 freeze fill: no write, no advance
//  busy           out  1                 high while state==FILL
//  done           out  1                 one-cycle pulse after final write
//  write_enable   out  1                 memory write strobe
//  write_addr     out  ADDR_WIDTH        memory write address
//  write_data     out  CHROMOSOME_WIDTH  memory write data = lfsr[CHROMOSOME_WIDTH-1:0]
//  init_checksum  out  CHROMOSOME_WIDTH  only with POP_INIT_CHECKSUM_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE, lfsr=16'hACE1, count=0. busy, done, write_enable,
//    write_addr, write_data and init_checksum all 0. Reset mid-fill aborts at once; no further writes.
//  - FSM: IDLE -(start)-> FILL -(last write, hold==0)-> DONE -> IDLE (unconditional).
//  - IDLE: start==1 at edge k -> FILL; lfsr<=(seed==0 ? 16'hACE1 : seed); count<=0.
//    The zero-seed substitution prevents LFSR lock-up.
//  - FILL: write_enable = ~hold (combinational from state and hold), write_addr = count,
//    write_data = lfsr[CW-1:0].
//    Each edge with hold==0: lfsr<=next(lfsr), count<=count+1.
//    hold==1: lfsr and count unchanged; write_enable=0.
//  - LFSR: Fibonacci, taps 16,14,13,11. fb = s[15]^s[13]^s[12]^s[10]; next = {s[14:0], fb}.
//  - Last write is at count==POPULATION_SIZE-1 with hold==0, then state becomes DONE.
//    count never wraps and never exceeds POPULATION_SIZE-1.
//  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. lfsr retains its value.
//  - Latency with no hold: start accepted at edge k; writes captured at edges k+1..k+POPULATION_SIZE;
//    done is high in the cycle after edge k+POPULATION_SIZE.
//  - start is ignored in FILL and DONE, so there is no restart mid-fill.
//    start is held high through DONE: a new fill begins on the first IDLE edge.
//  - busy = (state==FILL) and is independent of hold.
// CONFIGURATION
//  - Macro POP_INIT_CHECKSUM_EN.
//  - Defined: init_checksum port exists. Cleared to 0 on an accepted start. XOR-accumulates
//    write_data on every write, and is stable and valid from the done cycle until the next accepted start.
//  - Undefined: the port and the accumulator are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package ga_pkg: typedef enum logic [1:0] {INIT_IDLE, INIT_FILL, INIT_DONE} init_state_t;
//    localparam LFSR_WIDTH=16; localparam logic [15:0] LFSR_DEFAULT_SEED=16'hACE1.
//  - One sub-module: ga_lfsr16. Inputs: clk, rst_n, load, load_val, advance. Output: state.
//    It is reused by later mutation/crossover stages.
//  - Elaboration-time error if CHROMOSOME_WIDTH>16.
// TESTING
//  - Basic fill, CW=8, POP=16, seed=16'hACE1, start 1 cycle:
//    writes addr0=8'hE1, addr1=8'hC3, addr2=8'h87, ... addr15.
//    done pulses at start+17 edges; a connected population_memory read-back matches.
//  - Zero seed: seed=0 -> write sequence identical to seed=16'hACE1.
//  - Hold: assert hold for 3 cycles after the addr4 write -> no writes and addr/data frozen
//    during hold; the sequence resumes at addr5 with the unchanged value; done is delayed by 3 cycles.
//  - Start while busy: pulse start at addr7 with seed=16'h1234 -> ignored; sequence and
//    done timing are unchanged.
//  - Reset mid-fill: rst_n=0 at addr9 -> next cycle all outputs 0 and state IDLE.
//    A new start with seed=16'hACE1 replays from addr0=8'hE1.
//  - POP_INIT_CHECKSUM_EN: after the basic fill, init_checksum equals the XOR of the 16 written bytes
//    from the reference model. A second start clears it to 0 before accumulating.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared genetic-algorithm definitions: init FSM states and LFSR constants.
// Used by the population initializer and the later mutation/crossover stages.
package ga_pkg;

    typedef enum logic [1:0] {INIT_IDLE, INIT_FILL, INIT_DONE} init_state_t;

    localparam int          LFSR_WIDTH        = 16;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous load and advance.
// Load takes priority over advance; reset restores the default non-zero seed.
module ga_lfsr16
    import ga_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] load_val,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] state
);

    logic [LFSR_WIDTH-1:0] state_q;
    logic                  feedback;

    assign feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            state_q <= load_val;
        end else if (advance) begin
            state_q <= {state_q[LFSR_WIDTH-2:0], feedback};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/population_initializer.sv
// Fills every population slot with an LFSR chromosome, one write per cycle, then pulses done.
// Optional macro POP_INIT_CHECKSUM_EN adds an XOR checksum of all written chromosomes.
module population_initializer
    import ga_pkg::*;
#(
    parameter int CHROMOSOME_WIDTH = 8,
    parameter int POPULATION_SIZE  = 16,
    parameter int ADDR_WIDTH       = $clog2(POPULATION_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LFSR_WIDTH-1:0]       seed,
    input  logic                        hold,
    output logic                        busy,
    output logic                        done,
    output logic                        write_enable,
    output logic [ADDR_WIDTH-1:0]       write_addr,
`ifdef POP_INIT_CHECKSUM_EN
    output logic [CHROMOSOME_WIDTH-1:0] write_data,
    output logic [CHROMOSOME_WIDTH-1:0] init_checksum
`else
    output logic [CHROMOSOME_WIDTH-1:0] write_data
`endif
);

    if (CHROMOSOME_WIDTH < 1 || CHROMOSOME_WIDTH > LFSR_WIDTH) begin : g_bad_width
        $error("population_initializer: CHROMOSOME_WIDTH must be within 1..16");
    end
    if (POPULATION_SIZE < 2) begin : g_bad_size
        $error("population_initializer: POPULATION_SIZE must be at least 2");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(POPULATION_SIZE - 1);

    init_state_t           state_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [LFSR_WIDTH-1:0] lfsrState;
    logic [LFSR_WIDTH-1:0] loadValue;
    logic                  startAccepted;
    logic                  fillActive;

    assign fillActive    = (state_q == INIT_FILL);
    assign startAccepted = (state_q == INIT_IDLE) && start;
    // A zero seed would lock the LFSR at zero forever, so substitute the default.
    assign loadValue     = (seed == '0) ? LFSR_DEFAULT_SEED : seed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT_IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                INIT_IDLE: begin
                    if (start) begin
                        state_q <= INIT_FILL;
                        count_q <= '0;
                    end
                end
                INIT_FILL: begin
                    if (!hold) begin
                        if (count_q == LAST_ADDR) begin
                            state_q <= INIT_DONE;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                INIT_DONE: state_q <= INIT_IDLE;
                default:   state_q <= INIT_IDLE;
            endcase
        end
    end

    ga_lfsr16 u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (startAccepted),
        .load_val (loadValue),
        .advance  (write_enable),
        .state    (lfsrState)
    );

    // Address and data are forced to zero outside FILL so the memory port sees a quiet bus.
    assign busy         = fillActive;
    assign done         = (state_q == INIT_DONE);
    assign write_enable = fillActive & ~hold;
    assign write_addr   = fillActive ? count_q : '0;
    assign write_data   = fillActive ? lfsrState[CHROMOSOME_WIDTH-1:0] : '0;

`ifdef POP_INIT_CHECKSUM_EN
    logic [CHROMOSOME_WIDTH-1:0] checksum_q;
    logic [CHROMOSOME_WIDTH-1:0] checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (startAccepted) begin
            checksum_d = '0;
        end else if (write_enable) begin
            checksum_d = checksum_q ^ write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign init_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_population_initializer.sv
// Randomized self-checking bench for population_initializer against a sequence-level model.
// Compile with +define+POP_INIT_CHECKSUM_EN to also check the checksum output.
module tb_population_initializer;

    localparam int CW  = 8;
    localparam int POP = 16;
    localparam int AW  = $clog2(POP);

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          hold   = 1'b0;
    logic [15:0]   seed   = 16'h0000;
    logic          busy;
    logic          done;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [CW-1:0] write_data;
`ifdef POP_INIT_CHECKSUM_EN
    logic [CW-1:0] init_checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] seqData [POP];
    logic [CW-1:0] obsData [POP];
    logic [CW-1:0] expSum;

    population_initializer #(
        .CHROMOSOME_WIDTH (CW),
        .POPULATION_SIZE  (POP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .seed          (seed),
        .hold          (hold),
        .busy          (busy),
        .done          (done),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
`ifdef POP_INIT_CHECKSUM_EN
        .write_data    (write_data),
        .init_checksum (init_checksum)
`else
        .write_data    (write_data)
`endif
    );

    always #5 clk = ~clk;

    // Record what the memory would capture at the following rising edge.
    always @(negedge clk) begin
        if (write_enable === 1'b1) obsData[write_addr] = write_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // The whole expected chromosome sequence, derived from the shift-register rule.
    function automatic void buildModel(input logic [15:0] s0);
        int unsigned s;
        int unsigned fb;
        s = (s0 == 16'h0000) ? 32'hACE1 : 32'(s0);
        expSum = '0;
        for (int i = 0; i < POP; i++) begin
            seqData[i] = CW'(s % (1 << CW));
            expSum     = expSum ^ seqData[i];
            fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
            s  = ((s * 2) % 65536) + fb;
        end
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_we"}, write_enable, 0);
        checkOutput({tag, "_addr"}, write_addr, 0);
        checkOutput({tag, "_data"}, write_data, 0);
    endtask

    // mode: 0 no hold, 1 random hold, 2 three-cycle hold after addr4, 3 start pulse at addr7
    task automatic applyStimulus(input logic [15:0] s, input int mode, input int abortAt, input bit keepStart);
        int idx = 0;
        int cycles = 0;
        int holdRun = 0;
        buildModel(s);
        for (int i = 0; i < POP; i++) obsData[i] = '1;
        @(posedge clk); #1;
        start = 1'b1; seed = s; hold = 1'b0;
        @(posedge clk); #1;
        start = keepStart;
        seed  = 16'(($urandom));
        while (idx < POP && cycles < POP * 8) begin
            @(negedge clk);
            checkOutput("fill_busy", busy, 1);
            checkOutput("fill_done", done, 0);
            checkOutput("fill_we", write_enable, !hold);
            checkOutput("fill_addr", write_addr, idx);
            checkOutput("fill_data", write_data, seqData[idx]);
`ifdef POP_INIT_CHECKSUM_EN
            if (idx == 0) checkOutput("csum_clear", init_checksum, 0);
`endif
            if (idx == abortAt) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1; start = 1'b0; hold = 1'b0;
                @(negedge clk);
                checkIdle("abort");
`ifdef POP_INIT_CHECKSUM_EN
                checkOutput("abort_csum", init_checksum, 0);
`endif
                return;
            end
            @(posedge clk);
            if (!hold) idx++;
            cycles++;
            #1;
            case (mode)
                1: hold = ($urandom_range(0, 3) == 0);
                2: begin
                    hold = (idx == 5 && holdRun < 3);
                    if (hold) holdRun++;
                end
                3: begin
                    start = (idx == 7);
                    seed  = 16'h1234;
                end
                default: hold = 1'b0;
            endcase
            if (idx == POP) begin
                hold  = 1'b0;
                start = keepStart;
            end
        end
        if (idx < POP) begin
            checkOutput("fill_timeout", idx, POP);
            return;
        end
        @(negedge clk);
        checkOutput("done_pulse", done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_we", write_enable, 0);
`ifdef POP_INIT_CHECKSUM_EN
        checkOutput("csum_done", init_checksum, expSum);
`endif
        if (keepStart) begin
            seed = s;
            @(negedge clk);
            checkOutput("restart_idle", busy, 0);
            @(negedge clk);
            checkOutput("restart_busy", busy, 1);
            checkOutput("restart_data", write_data, seqData[0]);
`ifdef POP_INIT_CHECKSUM_EN
            checkOutput("restart_csum", init_checksum, 0);
`endif
            start = 1'b0;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            checkIdle("post");
`ifdef POP_INIT_CHECKSUM_EN
            checkOutput("csum_hold", init_checksum, expSum);
`endif
        end
    endtask

    initial begin
        $display("[TB] population_initializer bench starting");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
`ifdef POP_INIT_CHECKSUM_EN
        checkOutput("reset_csum", init_checksum, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus(16'hACE1, 0, -1, 1'b0);
        checkOutput("basic_addr0", obsData[0], 8'hE1);
        checkOutput("basic_addr1", obsData[1], 8'hC3);
        checkOutput("basic_addr2", obsData[2], 8'h87);
        for (int i = 0; i < POP; i++) checkOutput("basic_mem", obsData[i], seqData[i]);

        applyStimulus(16'h0000, 0, -1, 1'b0);
        checkOutput("zero_addr0", obsData[0], 8'hE1);

        applyStimulus(16'hACE1, 2, -1, 1'b0);
        applyStimulus(16'hACE1, 3, -1, 1'b0);
        applyStimulus(16'hACE1, 0, 9, 1'b0);
        applyStimulus(16'hACE1, 0, -1, 1'b0);
        checkOutput("replay_addr0", obsData[0], 8'hE1);

        for (int r = 0; r < 6; r++) begin
            applyStimulus(16'($urandom), 1, -1, 1'b0);
            for (int i = 0; i < POP; i++) checkOutput("rand_mem", obsData[i], seqData[i]);
        end
        applyStimulus(16'($urandom), 1, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
